// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU operation sequencer: main-control opcodes,
// R-type funct codes, the ALU command enum, the FSM state enum and the mode
// select for the iterative multiply/divide unit.
// Optional feature macro: ALU_OP_SEQUENCER_DIV_EN (enables DIV decode/datapath).
package alu_seq_pkg;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_MUL   = 2;
  localparam int OP_AND   = 3;
  localparam int OP_OR    = 4;
  localparam int OP_RTYPE = 5;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h19;
  localparam logic [5:0] FUNCT_DIV = 6'h1B;

  // Natural command width; the top-level CMD_W port is sized from this.
  localparam int CMD_W_NAT = 4;

  typedef enum logic [CMD_W_NAT-1:0] {
    CMD_ADD = 4'd0,
    CMD_SUB = 4'd1,
    CMD_MUL = 4'd2,
    CMD_AND = 4'd3,
    CMD_OR  = 4'd4,
    CMD_SLT = 4'd5,
    CMD_DIV = 4'd6,
    CMD_NOP = 4'd15
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef enum logic {
    ITER_MUL = 1'b0,
    ITER_DIV = 1'b1
  } iter_mode_e;

  function automatic logic is_iterative(alu_cmd_e cmd);
    return (cmd == CMD_MUL) || (cmd == CMD_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter
// Iterative datapath shared by the radix-2 shift-add multiplier and (when
// ALU_OP_SEQUENCER_DIV_EN is defined) the restoring divider. One bit is
// processed per 'step'; the parent owns the iteration down-counter and tells
// this block which step is the last one.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start          load operands (parent accept of an iterative op)
//   mode           ITER_MUL or ITER_DIV
//   a, b           operands (mul: a*b, div: a/b)
//   step           advance one bit this cycle
//   last           current step is the final one (parent counter == 0)
//   done           final step happening this cycle
//   lo_nxt, hi_nxt value the lo/hi registers take after this step
//                  (product low/high, or quotient/remainder)
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  iter_mode_e        mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              step,
  input  logic              last,
  output logic              done,
  output logic [DATA_W-1:0] lo_nxt,
  output logic [DATA_W-1:0] hi_nxt
);

`ifdef ALU_OP_SEQUENCER_DIV_EN
  // One extra bit so the carry out of (r_shift - d) shows the restore decision.
  localparam int ADD_W = DATA_W + 2;
`else
  localparam int ADD_W = DATA_W + 1;
`endif

  logic [DATA_W-1:0] acc_q;   // product high / partial remainder
  logic [DATA_W-1:0] q_q;     // multiplier shifting out / dividend->quotient
  logic [DATA_W-1:0] opd_q;   // multiplicand / divisor
  logic              load;
  logic [ADD_W-1:0]  add_a;
  logic [ADD_W-1:0]  add_b;
  logic [ADD_W-1:0]  sum;
  logic              cin;
  logic [DATA_W:0]   mul_acc;

`ifdef ALU_OP_SEQUENCER_DIV_EN
  iter_mode_e        mode_q;
  logic [DATA_W:0]   r_shift;
  logic              ge;

  assign load    = start;
  assign r_shift = {acc_q, q_q[DATA_W-1]};
`else
  // Without the divider only a multiply may start this unit.
  assign load = start && (mode == ITER_MUL);
`endif

  assign done = step && last;

  always_comb begin
    add_a = ADD_W'(acc_q);
    add_b = ADD_W'(opd_q);
    cin   = 1'b0;
`ifdef ALU_OP_SEQUENCER_DIV_EN
    if (mode_q == ITER_DIV) begin
      // r_shift - d as r_shift + ~d + 1 through the same adder
      add_a = ADD_W'(r_shift);
      add_b = ~ADD_W'(opd_q);
      cin   = 1'b1;
    end
`endif
    sum = add_a + add_b + ADD_W'(cin);

    mul_acc = q_q[0] ? sum[DATA_W:0] : {1'b0, acc_q};
    hi_nxt  = mul_acc[DATA_W:1];
    lo_nxt  = {mul_acc[0], q_q[DATA_W-1:1]};

`ifdef ALU_OP_SEQUENCER_DIV_EN
    ge = !sum[ADD_W-1];
    if (mode_q == ITER_DIV) begin
      hi_nxt = ge ? sum[DATA_W-1:0] : r_shift[DATA_W-1:0];
      lo_nxt = {q_q[DATA_W-2:0], ge};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      q_q    <= '0;
      opd_q  <= '0;
`ifdef ALU_OP_SEQUENCER_DIV_EN
      mode_q <= ITER_MUL;
`endif
    end else if (load) begin
      acc_q  <= '0;
`ifdef ALU_OP_SEQUENCER_DIV_EN
      mode_q <= mode;
      q_q    <= (mode == ITER_DIV) ? a : b;
      opd_q  <= (mode == ITER_DIV) ? b : a;
`else
      q_q    <= b;
      opd_q  <= a;
`endif
    end else if (step) begin
      acc_q <= hi_nxt;
      q_q   <= lo_nxt;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Decodes the main-control opcode (plus R-type funct) into an ALU command and
// executes it. ADD/SUB/AND/OR/SLT finish in one cycle; MUL (and DIV when
// ALU_OP_SEQUENCER_DIV_EN is defined) run DATA_W iterations in alu_seq_iter.
// Results are held under a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     request handshake for op/funct/a/b
//   op, funct, a, b       opcode, R-type function, operands
//   out_valid/out_ready   result handshake
//   result, hi            result / product low / quotient; product high / remainder
//   ctrl_command          decoded command held with the result
//   illegal               unsupported op/funct (qualified by out_valid)
//   busy                  iterative operation in progress
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no result pending, ready for a new op
// ST_ITER | multiply/divide iterating, one bit per cycle
// ST_DONE | result valid, waiting for out_ready
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CMD_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] hi,
  output logic [CMD_W-1:0]  ctrl_command,
  output logic              illegal,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  seq_state_e        state_q;
  seq_state_e        state_d;
  logic [CNT_W-1:0]  cnt_q;
  alu_cmd_e          dec_cmd;
  logic              dec_illegal;
  logic              dec_iter;
  logic [DATA_W-1:0] alu_res;
  logic              accept;
  iter_mode_e        iter_mode;
  logic              iter_done;
  logic [DATA_W-1:0] iter_lo;
  logic [DATA_W-1:0] iter_hi;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] hi_q;
  alu_cmd_e          cmd_q;
  logic              illegal_q;

  always_comb begin
    dec_cmd = CMD_NOP;
    case (op)
      OP_W'(OP_ADD): dec_cmd = CMD_ADD;
      OP_W'(OP_SUB): dec_cmd = CMD_SUB;
      OP_W'(OP_MUL): dec_cmd = CMD_MUL;
      OP_W'(OP_AND): dec_cmd = CMD_AND;
      OP_W'(OP_OR):  dec_cmd = CMD_OR;
      OP_W'(OP_RTYPE): begin
        case (funct)
          FUNCT_ADD: dec_cmd = CMD_ADD;
          FUNCT_SUB: dec_cmd = CMD_SUB;
          FUNCT_AND: dec_cmd = CMD_AND;
          FUNCT_OR:  dec_cmd = CMD_OR;
          FUNCT_SLT: dec_cmd = CMD_SLT;
          FUNCT_MUL: dec_cmd = CMD_MUL;
`ifdef ALU_OP_SEQUENCER_DIV_EN
          FUNCT_DIV: dec_cmd = CMD_DIV;
`endif
          default:   dec_cmd = CMD_NOP;
        endcase
      end
      default: dec_cmd = CMD_NOP;
    endcase
    dec_illegal = (dec_cmd == CMD_NOP);
    dec_iter    = is_iterative(dec_cmd);
  end

  always_comb begin
    alu_res = '0;
    case (dec_cmd)
      CMD_ADD: alu_res = a + b;
      CMD_SUB: alu_res = a - b;
      CMD_AND: alu_res = a & b;
      CMD_OR:  alu_res = a | b;
      CMD_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // Only path from out_ready to in_ready: a held result being drained.
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign iter_mode = (dec_cmd == CMD_DIV) ? ITER_DIV : ITER_MUL;

  alu_seq_iter #(
    .DATA_W (DATA_W)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && dec_iter),
    .mode   (iter_mode),
    .a      (a),
    .b      (b),
    .step   (state_q == ST_ITER),
    .last   (cnt_q == '0),
    .done   (iter_done),
    .lo_nxt (iter_lo),
    .hi_nxt (iter_hi)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = dec_iter ? ST_ITER : ST_DONE;
      end
      ST_ITER: begin
        if (iter_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (accept)         state_d = dec_iter ? ST_ITER : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      hi_q      <= '0;
      cmd_q     <= CMD_NOP;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q     <= dec_cmd;
        illegal_q <= dec_illegal;
        result_q  <= dec_iter ? '0 : alu_res;
        hi_q      <= '0;
        if (dec_iter) cnt_q <= CNT_W'(DATA_W - 1);
      end else if (state_q == ST_ITER) begin
        if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        if (iter_done) begin
          result_q <= iter_lo;
          hi_q     <= iter_hi;
        end
      end
    end
  end

  assign out_valid    = (state_q == ST_DONE);
  assign busy         = (state_q == ST_ITER);
  assign result       = result_q;
  assign hi           = hi_q;
  assign ctrl_command = CMD_W'(cmd_q);
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [3:0]    op = '0;
  logic [5:0]    funct = '0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] result;
  logic [DW-1:0] hi;
  logic [3:0]    ctrl_command;
  logic          illegal;
  logic          busy;

  int compared = 0;
  int mismatched = 0;

  alu_op_sequencer #(
    .DATA_W (DW),
    .OP_W   (4),
    .CMD_W  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .funct        (funct),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .hi           (hi),
    .ctrl_command (ctrl_command),
    .illegal      (illegal),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the command/funct tables.
  task automatic model(input logic [3:0] o, input logic [5:0] f,
                       input logic [DW-1:0] x, input logic [DW-1:0] y,
                       output logic [3:0] cmd, output logic ill,
                       output logic [DW-1:0] res, output logic [DW-1:0] h,
                       output int lat);
    logic [63:0] p;
    int c;
    c = 15;
    case (o)
      4'd0: c = 0;
      4'd1: c = 1;
      4'd2: c = 2;
      4'd3: c = 3;
      4'd4: c = 4;
      4'd5: begin
        case (f)
          6'h20: c = 0;
          6'h22: c = 1;
          6'h24: c = 3;
          6'h25: c = 4;
          6'h2A: c = 5;
          6'h19: c = 2;
`ifdef ALU_OP_SEQUENCER_DIV_EN
          6'h1B: c = 6;
`endif
          default: c = 15;
        endcase
      end
      default: c = 15;
    endcase
    cmd = 4'(c);
    ill = (c == 15);
    h   = '0;
    res = '0;
    lat = 1;
    case (c)
      0: res = x + y;
      1: res = x - y;
      3: res = x & y;
      4: res = x | y;
      5: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      2: begin
        p   = 64'(x) * 64'(y);
        res = p[31:0];
        h   = p[63:32];
        lat = DW + 1;
      end
      6: begin
        if (y == 0) begin
          res = '1;
          h   = x;
        end else begin
          res = x / y;
          h   = x % y;
        end
        lat = DW + 1;
      end
      default: ;
    endcase
  endtask

  // Issue one op from IDLE, measure latency, compare everything, then drain.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [5:0] f,
                        input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [3:0]    ecmd;
    logic          eill;
    logic [DW-1:0] eres;
    logic [DW-1:0] ehi;
    int            elat;
    int            lat;
    int            busy_cnt;
    int            rdy_seen;
    model(o, f, x, y, ecmd, eill, eres, ehi, elat);
    op = o; funct = f; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom); funct = 6'($urandom);
    lat = 1; busy_cnt = 0; rdy_seen = 0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cnt++;
      if (in_ready) rdy_seen++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(elat - 1));
    chk({tag, ".in_ready_while_busy"}, 64'(rdy_seen), 64'(0));
    chk({tag, ".result"}, 64'(result), 64'(eres));
    chk({tag, ".hi"}, 64'(hi), 64'(ehi));
    chk({tag, ".cmd"}, 64'(ctrl_command), 64'(ecmd));
    chk({tag, ".illegal"}, 64'(illegal), 64'(eill));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [5:0]    funct_tab [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h19, 6'h1B};
  logic [DW-1:0] edge_tab  [4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  function automatic logic [DW-1:0] pick_operand();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 15);
      1: return edge_tab[$urandom_range(0, 3)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] held;
    logic [3:0]    ro;
    logic [5:0]    rf;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'(0));
    chk("rst.result", 64'(result), 64'(0));
    chk("rst.hi", 64'(hi), 64'(0));
    chk("rst.cmd", 64'(ctrl_command), 64'(15));
    chk("rst.illegal", 64'(illegal), 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_7_5", 4'd0, 6'h00, 32'd7, 32'd5);
    run_op("slt_neg", 4'd5, 6'h2A, 32'hFFFFFFFF, 32'd1);
    run_op("slt_eq", 4'd5, 6'h2A, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mul_ff_2", 4'd2, 6'h00, 32'hFFFFFFFF, 32'd2);
    run_op("sub_wrap", 4'd1, 6'h00, 32'd0, 32'd1);
    run_op("add_wrap", 4'd5, 6'h20, 32'hFFFFFFFF, 32'd1);
    run_op("mul_rtype", 4'd5, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("div_100_7", 4'd5, 6'h1B, 32'd100, 32'd7);
    run_op("div_by_0", 4'd5, 6'h1B, 32'd9, 32'd0);
    run_op("bad_op", 4'd9, 6'h20, 32'd3, 32'd4);
    run_op("bad_funct", 4'd5, 6'h3F, 32'd3, 32'd4);

    // Result held while out_ready is low, then drained with a new ADD.
    x = $urandom; y = $urandom;
    op = 4'd0; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    held = x + y;
    for (int i = 0; i < 5; i++) begin
      chk("hold.out_valid", 64'(out_valid), 64'(1));
      chk("hold.result", 64'(result), 64'(held));
      chk("hold.in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    x = $urandom; y = $urandom;
    op = 4'd0; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("release.in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    chk("release.out_valid", 64'(out_valid), 64'(1));
    chk("release.result", 64'(result), 64'(x + y));

    // Back-to-back single-cycle ops, one result per cycle.
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom;
      a = x; b = y; op = 4'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b.out_valid", 64'(out_valid), 64'(1));
      chk("b2b.result", 64'(result), 64'(x & y));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b.drained", 64'(out_valid), 64'(0));

    // Reset in the middle of a multiply.
    op = 4'd2; a = $urandom; b = $urandom; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midrst.busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst.out_valid", 64'(out_valid), 64'(0));
    chk("midrst.result", 64'(result), 64'(0));
    chk("midrst.hi", 64'(hi), 64'(0));
    chk("midrst.cmd", 64'(ctrl_command), 64'(15));
    chk("midrst.illegal", 64'(illegal), 64'(0));
    chk("midrst.busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst_add", 4'd0, 6'h00, 32'd123, 32'd456);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) rf = 6'($urandom);
      else rf = funct_tab[$urandom_range(0, 6)];
      run_op("rand", ro, rf, pick_operand(), pick_operand());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Parametrised successor to the single-cycle ALU control decoder: it decodes the main-control opcode plus the R-type `funct` field into an ALU command and executes it. Logic ops complete in one cycle; multiply (and optionally divide) run as an iterative multi-cycle sequence. A valid/ready handshake lets the execute stage stall on long operations. It sits between the main control unit / register-read stage and the EX/MEM pipeline register.

## Interface
- `DATA_W`, 32: operand/result width; must be ≥ 4
- `OP_W`, 4: width of the opcode from main control
- `CMD_W`, 4: width of the `ctrl_command` output
- `clk` in 1: the single clock; all logic on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `in_valid` in 1: `op`/`funct`/`a`/`b` valid
- `in_ready` out 1: block accepts on `in_valid && in_ready`
- `op` in OP_W: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 RTYPE (use `funct`); others are illegal
- `funct` in 6: R-type function; used only when `op`=5
- `a`, `b` in DATA_W: operands
- `out_valid` out 1: result valid, held until `out_ready`
- `out_ready` in 1: consumer accepts the result
- `result` out DATA_W: ALU result / product low / quotient
- `hi` out DATA_W: product high / remainder; 0 for single-cycle ops
- `ctrl_command` out CMD_W: decoded command, held with `result`
- `illegal` out 1: unsupported op/funct, qualified by `out_valid`
- `busy` out 1: an iterative operation is in progress

## Operation
- Command codes: ADD=0, SUB=1, MUL=2, AND=3, OR=4, SLT=5, DIV=6, NOP=15.
- RTYPE `funct` map: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x19 MUL, 0x1B DIV (only with macro).
- Any other `op` or `funct` decodes to NOP: `illegal`=1, `result`=0, `hi`=0, single-cycle.
- ADD/SUB wrap modulo 2^DATA_W; there is no overflow trap. SLT is signed compare, `result` = {0…,lt}.
- MUL is unsigned, radix-2 shift-add. `{hi,result}` = 2·DATA_W-bit product.
- DIV is unsigned, restoring. `result` = quotient, `hi` = remainder. With `b`=0: `result` = all ones, `hi` = `a`, with the same latency (no special case).
- Operands are captured at accept; later input changes are ignored.
- FSM states: IDLE, ITER, DONE.
  - IDLE: on accept of a single-cycle op → DONE; of MUL/DIV → ITER with counter loaded to DATA_W-1.
  - ITER: one bit per cycle; at counter = 0 → DONE.
  - DONE: `out_valid`=1. On `out_ready`: if a new op is accepted in the same cycle, branch as from IDLE; otherwise → IDLE.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready).
- `busy` = (state==ITER).
- Reset values: state IDLE; `out_valid` 0, `result` 0, `hi` 0, `ctrl_command` NOP, `illegal` 0, `busy` 0; counter 0.
- Reset mid-ITER aborts the operation; no result is produced.

## Timing
- Single-cycle op: accepted at edge N, `out_valid` at N+1.
- MUL/DIV: accepted at N, `out_valid` at N+DATA_W+1 (33 cycles for DATA_W=32).
- Back-to-back single-cycle ops with `out_ready` held high: one result per cycle.
- Outputs are registered; no combinational path from `in_*` to `out_*`. `in_ready` depends combinationally on `out_ready` only in DONE.
- Counter width is $clog2(DATA_W).

## Configuration
- `ALU_OP_SEQUENCER_DIV_EN` defined: DIV decode (funct 0x1B) and the restoring-divide path are built in.
- Undefined: funct 0x1B is illegal (NOP, 1 cycle), and the divide datapath is absent.

## Structure
- Package `alu_seq_pkg`: op codes, funct constants, command enum (CMD_W), FSM state enum.
- Sub-module `alu_seq_iter`: shared shift register / adder for shift-add multiply and restoring divide. It has start/mode/done controls and is driven by the parent's counter.
- The parent holds decode, the single-cycle ALU, FSM, handshake and output registers.

## Test plan
- Reset, then `op`=0 with a=7, b=5 → one cycle later `result`=12, `ctrl_command`=0, `hi`=0, `illegal`=0.
- `op`=5, `funct`=0x2A, a=0xFFFFFFFF, b=1 → `result`=1 (signed −1<1). Then a=0xFFFFFFFF, b=0xFFFFFFFF with the same funct → `result`=0.
- `op`=2, a=0xFFFFFFFF, b=2 → `busy` high for 32 cycles, then `out_valid`; `result`=0xFFFFFFFE, `hi`=1, and `in_ready`=0 throughout.
- With macro: DIV a=100, b=7 → `result`=14, `hi`=2, after 33 cycles. DIV a=9, b=0 → `result`=0xFFFFFFFF, `hi`=9. Without macro: funct 0x1B → `illegal`=1 after 1 cycle.
- Hold `out_ready`=0 for 5 cycles after a result → `result`/`out_valid` stable and `in_ready`=0. Releasing it with a new ADD on `in_valid` → new result the next cycle.
- Assert `rst_n`=0 during the 10th MUL iteration → next cycle all outputs at reset values. The next ADD completes normally.
